datapath_sequencer: RTL and testbench
=====================================

# datapath_sequencer

Control unit that drives the 4-bit register/memory datapath (R1, R2, AR, 16x4 memory, two 4-way buses, add/sub ALU) from single-word instructions. It accepts an opcode plus 4-bit immediate through a start/busy/done handshake. It then sequences the datapath control word (load enables, bus selects, ALU function, memory read/write, immediate on `x`) over one or two execute cycles. It sits between an instruction source (switch panel or test bench) and the datapath's control inputs.

## Interface
- `SEL_X`, 2'd0, bus select code for immediate `x`
- `SEL_R1`, 2'd1, bus select code for R1
- `SEL_R2`, 2'd2, bus select code for R2
- `SEL_MEM`, 2'd3, bus select code for memory read data
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `op`  in  3  opcode, latched with `start`
- `imm`  in  4  immediate, latched with `start`
- `busy`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  illegal opcode flag; valid only while `done`=1
- `x`  out  4  immediate driven to datapath bus input 0
- `l1`, `l2`, `l3`  out  1 each  load enables for R1, R2, AR
- `s1`, `s2`  out  2 each  bus1/bus2 source selects
- `f`  out  1  ALU function: 0 = bus1+bus2, 1 = bus1-bus2 (mod 16)
- `w`, `r`  out  1 each  memory write / read at address AR

## Operation
- States: IDLE, ZERO, EXEC, DONE.
- IDLE + `start`=1: latch `op`/`imm`. Go to EXEC for 1-step ops, ZERO for 2-step ops, DONE (err) for illegal ops.
- ZERO: x=imm, s1=s2=SEL_X, f=1, l2=1 (R2 <- 0). Always followed by EXEC.
- EXEC control word per op (all unlisted controls 0):
  - 0 ADD (1-step): s1=SEL_R1, s2=SEL_R2, f=0, l1=1. Result: R1 <- R1+R2.
  - 1 SUB (1-step): as ADD with f=1. Result: R1 <- R1-R2.
  - 2 LDI (2-step): x=imm, s1=SEL_X, s2=SEL_R2, f=0, l1=1. Result: R1 <- imm.
  - 3 SETAR (2-step): as LDI but l3=1 instead of l1. Result: AR <- imm.
  - 4 STORE (2-step): s1=SEL_R1, s2=SEL_R2, f=0, w=1. Result: M[AR] <- R1.
  - 5 LOAD (2-step): r=1, s1=SEL_MEM, s2=SEL_R2, f=0, l1=1. Result: R1 <- M[AR].
  - 6, 7: illegal. Skip ZERO/EXEC; no control asserted; err=1 in DONE.
- All 2-step ops leave R2 = 0. This is architectural, not a side effect to hide.
- DONE: done=1, err per op; all controls idle; next state IDLE.
- Idle control word (IDLE, DONE, reset): x=0, s1=s2=0, f=0, l1=l2=l3=0, w=r=0.
- Control outputs decode only from state and latched op/imm, never from live inputs. `op`/`imm` changes while busy have no effect.
- `start` in any state other than IDLE is ignored. It is not queued.

## Timing
- Reset (async assert): state=IDLE, busy=0, done=0, err=0, idle control word, latched op/imm=0. Takes effect immediately, without waiting for a clock edge.
- Reset mid-operation: any load/write captured at an edge before assertion stands; nothing after. No done pulse.
- Start edge E0. 1-step ops: EXEC in cycle E0..E1, datapath captures at E1, DONE in E1..E2, IDLE from E2.
- 2-step ops: ZERO E0..E1, EXEC E1..E2, DONE E2..E3.
- Illegal ops: DONE E0..E1.
- `w` is high for exactly one cycle per STORE. AR and bus values are stable for that whole cycle.
- `start` held high continuously: a new op is accepted at the first IDLE edge, i.e. one cycle after DONE.
- ALU arithmetic is 4-bit wrap-around. The sequencer does no width checks.

## Test plan
- Reset: assert rst_n=0 mid-cycle with no clock edge. All outputs go to 0 immediately. Release, idle 3 cycles: busy=0, no done.
- LDI 9, then ADD with R2=0 (datapath model attached): R1=9, R2=0. Done appears 3 cycles after LDI start and 2 cycles after ADD start. SUB with R1=9, R2=0 gives R1=9. After LDI 3 then SUB: R1=3.
- SETAR 5, LDI 12, STORE, LDI 0, LOAD: M[5]=12, final R1=12. `w` high exactly 1 cycle, `r` high exactly 1 cycle.
- op=6 with imm=15: done=1 and err=1 one cycle after start. No l*/w/r asserted. Datapath unchanged.
- Issue LDI; while busy, pulse start with op=ADD and change imm: op ignored; R1 = original imm.
- Deassert rst_n during ZERO of a STORE: no w pulse, no done, R2=0 (captured), memory unchanged.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Sequencer for the 4-bit R1/R2/AR/memory datapath. It accepts one opcode and immediate
// per start/busy/done handshake, then drives the datapath control word for one or two cycles.
module datapath_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [3:0] imm,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] x,
  output logic       l1,
  output logic       l2,
  output logic       l3,
  output logic [1:0] s1,
  output logic [1:0] s2,
  output logic       f,
  output logic       w,
  output logic       r
);

  localparam logic [1:0] SEL_X   = 2'd0;
  localparam logic [1:0] SEL_R1  = 2'd1;
  localparam logic [1:0] SEL_R2  = 2'd2;
  localparam logic [1:0] SEL_MEM = 2'd3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_LDI   = 3'd2;
  localparam logic [2:0] OP_SETAR = 3'd3;
  localparam logic [2:0] OP_STORE = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;

  typedef enum logic [1:0] {IDLE, ZERO, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [3:0] imm_q;
  logic       illegal_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
      imm_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_q  <= op;
        imm_q <= imm;
      end
    end
  end

  // Opcodes 6 and 7 are the only illegal encodings.
  assign illegal_q = (op_q[2:1] == 2'b11);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_ADD, OP_SUB:                      state_nxt = EXEC;
            OP_LDI, OP_SETAR, OP_STORE, OP_LOAD: state_nxt = ZERO;
            default:                             state_nxt = DONE;
          endcase
        end
      end
      ZERO:    state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets its idle value first so no path through the case infers a latch.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    err  = (state == DONE) && illegal_q;
    x    = '0;
    l1   = 1'b0;
    l2   = 1'b0;
    l3   = 1'b0;
    s1   = SEL_X;
    s2   = SEL_X;
    f    = 1'b0;
    w    = 1'b0;
    r    = 1'b0;
    case (state)
      ZERO: begin
        // imm - imm clears R2 so the EXEC step can use R2 as an additive zero.
        x  = imm_q;
        s1 = SEL_X;
        s2 = SEL_X;
        f  = 1'b1;
        l2 = 1'b1;
      end
      EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            s1 = SEL_R1;
            s2 = SEL_R2;
            f  = (op_q == OP_SUB);
            l1 = 1'b1;
          end
          OP_LDI, OP_SETAR: begin
            x  = imm_q;
            s1 = SEL_X;
            s2 = SEL_R2;
            l1 = (op_q == OP_LDI);
            l3 = (op_q == OP_SETAR);
          end
          OP_STORE: begin
            s1 = SEL_R1;
            s2 = SEL_R2;
            w  = 1'b1;
          end
          OP_LOAD: begin
            r  = 1'b1;
            s1 = SEL_MEM;
            s2 = SEL_R2;
            l1 = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with a small R1/R2/AR/memory model driven by the
// sequencer's control word; expected values are hand-computed.
module tb_datapath_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] imm = 4'd0;
  logic       busy, done, err, l1, l2, l3, f, w, r;
  logic [3:0] x;
  logic [1:0] s1, s2;

  int checks = 0;
  int errors = 0;

  datapath_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .imm(imm),
    .busy(busy), .done(done), .err(err), .x(x),
    .l1(l1), .l2(l2), .l3(l3), .s1(s1), .s2(s2), .f(f), .w(w), .r(r)
  );

  always #5 clk = ~clk;

  // Datapath model: buses, ALU and registers react only to the sequencer's outputs.
  logic [3:0] r1m = 4'd0, r2m = 4'd0, arm = 4'd0;
  logic [3:0] mem [16];
  int wcnt = 0, rcnt = 0, dcnt = 0;

  function automatic logic [3:0] pick(input logic [1:0] sel);
    case (sel)
      2'd0:    return x;
      2'd1:    return r1m;
      2'd2:    return r2m;
      default: return mem[arm];
    endcase
  endfunction

  always @(posedge clk) begin : dp
    logic [3:0] b1, b2, a;
    b1 = pick(s1);
    b2 = pick(s2);
    a  = f ? b1 - b2 : b1 + b2;
    if (l1) r1m <= a;
    if (l2) r2m <= a;
    if (l3) arm <= a;
    if (w) begin
      mem[arm] <= a;
      wcnt <= wcnt + 1;
    end
    if (r) rcnt <= rcnt + 1;
    if (done) dcnt <= dcnt + 1;
  end

  logic [13:0] cw;
  assign cw = {x, l1, l2, l3, s1, s2, f, w, r};

  function automatic logic [13:0] mk(input logic [3:0] xv, input logic a1, input logic a2,
                                     input logic a3, input logic [1:0] b1, input logic [1:0] b2,
                                     input logic fv, input logic wv, input logic rv);
    return {xv, a1, a2, a3, b1, b2, fv, wv, rv};
  endfunction

  localparam logic [13:0] CW_IDLE = 14'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request before edge E0 and returns 1 time unit after E0.
  task automatic issue(input logic [2:0] o, input logic [3:0] i);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    imm   = i;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [3:0] i, input logic [13:0] exec_cw,
                        input string tag);
    issue(o, i);
    if (o >= 3'd2 && o <= 3'd5) step();
    if (o <= 3'd5) begin
      check({tag, " exec_cw"}, 32'(cw), 32'(exec_cw));
      step();
    end
    check({tag, " busy_done_err"}, 32'({busy, done, err}), 32'({2'b11, (o >= 3'd6)}));
    step();
    check({tag, " back_idle"}, 32'({busy, done, cw}), 32'(0));
  endtask

  initial begin
    int w0, r0, d0;
    for (int k = 0; k < 16; k++) mem[k] = 4'd0;

    // Reset held from time zero, before any clock edge.
    #2;
    check("reset outputs", 32'({busy, done, err, cw}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle after reset", 32'({busy, done}), 32'(0));
    end

    // LDI 9 with full cycle-by-cycle control word.
    issue(3'd2, 4'd9);
    check("ldi zero_cw", 32'({busy, cw}), 32'({1'b1, mk(4'd9, 0, 1, 0, 2'd0, 2'd0, 1, 0, 0)}));
    step();
    check("ldi exec_cw", 32'({done, cw}), 32'({1'b0, mk(4'd9, 1, 0, 0, 2'd0, 2'd2, 0, 0, 0)}));
    step();
    check("ldi done", 32'({busy, done, err, cw}), 32'({3'b110, CW_IDLE}));
    step();
    check("ldi idle", 32'({busy, done}), 32'(0));
    check("ldi r1_r2", 32'({r1m, r2m}), 32'h90);

    run_op(3'd0, 4'd0, mk(4'd0, 1, 0, 0, 2'd1, 2'd2, 0, 0, 0), "add");
    check("add r1", 32'(r1m), 32'd9);
    run_op(3'd1, 4'd0, mk(4'd0, 1, 0, 0, 2'd1, 2'd2, 1, 0, 0), "sub");
    check("sub r1", 32'(r1m), 32'd9);
    run_op(3'd2, 4'd3, mk(4'd3, 1, 0, 0, 2'd0, 2'd2, 0, 0, 0), "ldi3");
    run_op(3'd1, 4'd0, mk(4'd0, 1, 0, 0, 2'd1, 2'd2, 1, 0, 0), "sub2");
    check("ldi3 sub r1", 32'(r1m), 32'd3);

    // Memory round trip through AR = 5.
    run_op(3'd3, 4'd5, mk(4'd5, 0, 0, 1, 2'd0, 2'd2, 0, 0, 0), "setar");
    run_op(3'd2, 4'd12, mk(4'd12, 1, 0, 0, 2'd0, 2'd2, 0, 0, 0), "ldi12");
    w0 = wcnt;
    run_op(3'd4, 4'd0, mk(4'd0, 0, 0, 0, 2'd1, 2'd2, 0, 1, 0), "store");
    check("store w pulses", 32'(wcnt - w0), 32'd1);
    run_op(3'd2, 4'd0, mk(4'd0, 1, 0, 0, 2'd0, 2'd2, 0, 0, 0), "ldi0");
    check("ldi0 r1", 32'(r1m), 32'd0);
    r0 = rcnt;
    run_op(3'd5, 4'd0, mk(4'd0, 1, 0, 0, 2'd3, 2'd2, 0, 0, 1), "load");
    check("load r pulses", 32'(rcnt - r0), 32'd1);
    check("mem5 ar r1 r2", 32'({mem[5], arm, r1m, r2m}), 32'h45C0 | 32'hC000);

    // Illegal opcode: done+err one cycle after start, nothing else moves.
    w0 = wcnt;
    issue(3'd6, 4'd15);
    check("illegal done_err_cw", 32'({busy, done, err, cw}), 32'({3'b111, CW_IDLE}));
    step();
    check("illegal idle", 32'({busy, done, err}), 32'(0));
    check("illegal no change", 32'({r1m, r2m, arm, mem[5]}), 32'hC05C);
    check("illegal no write", 32'(wcnt - w0), 32'd0);
    run_op(3'd7, 4'd1, CW_IDLE, "illegal7");

    // Start pulsed while busy is ignored.
    issue(3'd2, 4'd7);
    start = 1'b1;
    op    = 3'd0;
    imm   = 4'd2;
    step();
    start = 1'b0;
    check("busy ignore exec_cw", 32'(cw), 32'(mk(4'd7, 1, 0, 0, 2'd0, 2'd2, 0, 0, 0)));
    step();
    check("busy ignore done", 32'({busy, done, err}), 32'(3'b110));
    step();
    check("busy ignore idle", 32'({busy, done}), 32'(0));
    step();
    check("busy ignore stays idle", 32'(busy), 32'(0));
    check("busy ignore r1", 32'(r1m), 32'd7);

    // Start held high: next op accepted one cycle after DONE.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd2;
    imm   = 4'd4;
    step();
    step();
    step();
    check("held done", 32'({busy, done}), 32'(2'b11));
    step();
    check("held idle gap", 32'({busy, done}), 32'(0));
    step();
    start = 1'b0;
    check("held reaccept", 32'({busy, cw}), 32'({1'b1, mk(4'd4, 0, 1, 0, 2'd0, 2'd0, 1, 0, 0)}));
    step();
    step();
    step();
    check("held r1 busy", 32'({r1m, 3'b000, busy}), 32'h40);

    // Reset asserted mid-cycle during ZERO of a STORE.
    w0 = wcnt;
    d0 = dcnt;
    issue(3'd4, 4'd9);
    check("store zero_cw", 32'(cw), 32'(mk(4'd9, 0, 1, 0, 2'd0, 2'd0, 1, 0, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", 32'({busy, done, err, cw}), 32'(0));
    step();
    step();
    check("reset no write", 32'(wcnt - w0), 32'd0);
    check("reset no done", 32'(dcnt - d0), 32'd0);
    check("reset datapath", 32'({r2m, mem[5], r1m}), 32'h0C4);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("after reset idle", 32'({busy, done, cw}), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
